// File: rtl/fifo_rd_burst_drainer.sv
// Read-side burst drainer: pops burst_len words from the async FIFO and streams them out
// through a 3-entry buffer. Define RD_STATS_EN to compile in the stat_words/stat_starve counters.
module fifo_rd_burst_drainer #(
   parameter  int width = 32,
   parameter  int depth = 1024,
   localparam int LEN_W = $clog2(depth) + 1
) (
   input  logic             clk_r,
   input  logic             reset_r,
   input  logic             start,
   input  logic [LEN_W-1:0] burst_len,
   input  logic             abort,
   input  logic [width-1:0] rdata,
   input  logic             empty,
   output logic             red_enable,
   output logic [width-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic             busy,
   output logic             done,
   output logic [31:0]      stat_words,
   output logic [31:0]      stat_starve
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   logic [1:0]       rst_sync_q, rst_sync_d;
   logic             rst_n;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic             done_q, done_d;
   logic             inflight_q, inflight_d;
   logic             inflight_last_q, inflight_last_d;
   logic [1:0]       occ_q, occ_d;
   logic [width-1:0] buf_data_q [3];
   logic [width-1:0] buf_data_d [3];
   logic [2:0]       buf_last_q, buf_last_d;
   logic [1:0]       wr_idx;

   logic             abort_hit;
   logic             pop;
   logic             push;

   // Reset asserts immediately and releases two clk_r edges after reset_r rises.
   always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

   always_ff @(posedge clk_r or negedge reset_r) begin
      if (!reset_r) rst_sync_q <= 2'b00;
      else          rst_sync_q <= rst_sync_d;
   end

   assign rst_n = rst_sync_q[1];

   // Downstream handshake: a word transfers on a cycle with m_valid & m_ready; while
   // m_valid is high and m_ready low, m_data/m_last/m_valid stay unchanged.
   // abort outranks a transfer on the same cycle, so that word is dropped, not delivered.
   assign abort_hit = abort & (state_q != ST_IDLE);
   assign pop       = m_valid & m_ready & ~abort_hit;
   assign push      = inflight_q & ~abort_hit;

   // FSM state register
   always_ff @(posedge clk_r or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         done_q      <= done_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (burst_len != '0) begin
                  state_d     = ST_RUN;
                  remaining_d = burst_len;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d     = ST_IDLE;
               remaining_d = '0;
               done_d      = 1'b1;
            end else if (red_enable) begin
               remaining_d = remaining_q - LEN_ONE;
               if (remaining_q == LEN_ONE) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Leave on the edge that empties the pipeline so done and !busy line up.
            if (abort || (occ_d == 2'd0 && !inflight_d)) begin
               state_d     = ST_IDLE;
               remaining_d = '0;
               done_d      = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            remaining_d = '0;
         end
      endcase
   end

   // FSM outputs; red_enable depends only on registered state and the FIFO flag.
   always_comb begin
      busy       = (state_q != ST_IDLE);
      red_enable = (state_q == ST_RUN) && !empty && (remaining_q != '0) &&
                   (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
      m_valid    = (occ_q != 2'd0);
      m_data     = buf_data_q[0];
      m_last     = m_valid & buf_last_q[0];
      done       = done_q;
   end

   // Read pipeline and output buffer; entry 0 is always the head.
   always_comb begin
      inflight_d      = red_enable & ~abort_hit;
      inflight_last_d = red_enable & ~abort_hit & (remaining_q == LEN_ONE);
      buf_data_d      = buf_data_q;
      buf_last_d      = buf_last_q;
      occ_d           = occ_q;
      wr_idx          = occ_q;
      if (abort_hit) begin
         occ_d = 2'd0;
      end else begin
         if (pop) begin
            buf_data_d[0] = buf_data_q[1];
            buf_data_d[1] = buf_data_q[2];
            buf_last_d    = {1'b0, buf_last_q[2:1]};
            wr_idx        = occ_q - 2'd1;
         end
         if (push) begin
            for (int i = 0; i < 3; i++) begin
               if (wr_idx == 2'(i)) begin
                  buf_data_d[i] = rdata;
                  buf_last_d[i] = inflight_last_q;
               end
            end
         end
         case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk_r or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         occ_q           <= 2'd0;
         buf_last_q      <= 3'b000;
         for (int i = 0; i < 3; i++) buf_data_q[i] <= '0;
      end else begin
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         occ_q           <= occ_d;
         buf_last_q      <= buf_last_d;
         for (int i = 0; i < 3; i++) buf_data_q[i] <= buf_data_d[i];
      end
   end

`ifdef RD_STATS_EN
   logic [31:0] stat_words_q, stat_words_d;
   logic [31:0] stat_starve_q, stat_starve_d;

   always_comb begin
      stat_words_d  = stat_words_q + (pop ? 32'd1 : 32'd0);
      stat_starve_d = stat_starve_q +
                      (((state_q == ST_RUN) && empty && (remaining_q != '0)) ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk_r or negedge rst_n) begin
      if (!rst_n) begin
         stat_words_q  <= 32'd0;
         stat_starve_q <= 32'd0;
      end else begin
         stat_words_q  <= stat_words_d;
         stat_starve_q <= stat_starve_d;
      end
   end

   assign stat_words  = stat_words_q;
   assign stat_starve = stat_starve_q;
`else
   assign stat_words  = 32'd0;
   assign stat_starve = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_burst_drainer.sv
// Bench for fifo_rd_burst_drainer: FIFO model, directed bursts plus random bursts, and a
// negedge monitor comparing the DUT against a transaction-level model and expected queue.
module tb_fifo_rd_burst_drainer;
   localparam int W     = 32;
   localparam int LEN_W = 11;

   logic             clk_r = 1'b0;
   logic             reset_r;
   logic             start;
   logic [LEN_W-1:0] burst_len;
   logic             abort;
   logic [W-1:0]     rdata;
   logic             empty;
   logic             red_enable;
   logic [W-1:0]     m_data;
   logic             m_valid;
   logic             m_ready;
   logic             m_last;
   logic             busy;
   logic             done;
   logic [31:0]      stat_words;
   logic [31:0]      stat_starve;

   int checks = 0;
   int errors = 0;

   logic [W:0]   exp_q[$];
   logic [W-1:0] fifo_q[$];
   logic         force_empty = 1'b0;
   logic         re_s = 1'b0;
   int           rel_cnt = 0;

   int           mdl_len = 0, mdl_issued = 0, mdl_delivered = 0, occ_m = 0;
   bit           mdl_active = 0, mdl_inflight = 0, done_exp = 0;
   bit           exp_re, new_done, was_active;
   int           stat_w = 0, stat_s = 0;
   bit           prev_hold = 0;
   logic [W-1:0] prev_data;
   logic         prev_last;
   logic [W:0]   e_word;

   int t_re   [7] = '{1, 1, 1, 1, 0, 0, 0};
   int t_mv   [7] = '{0, 0, 1, 1, 1, 1, 0};
   int t_busy [7] = '{1, 1, 1, 1, 1, 1, 0};
   int t_done [7] = '{0, 0, 0, 0, 0, 0, 1};
   int t_last [7] = '{0, 0, 0, 0, 0, 1, 0};

   fifo_rd_burst_drainer #(.width(W), .depth(1024)) dut (
      .clk_r       (clk_r),
      .reset_r     (reset_r),
      .start       (start),
      .burst_len   (burst_len),
      .abort       (abort),
      .rdata       (rdata),
      .empty       (empty),
      .red_enable  (red_enable),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_last      (m_last),
      .busy        (busy),
      .done        (done),
      .stat_words  (stat_words),
      .stat_starve (stat_starve)
   );

   // Clock and reset-release tracking
   always #5 clk_r = ~clk_r;

   always @(posedge clk_r or negedge reset_r) begin
      if (!reset_r)         rel_cnt <= 0;
      else if (rel_cnt < 3) rel_cnt <= rel_cnt + 1;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, expv, $time);
      end
   endtask

   task automatic upd_empty();
      empty = force_empty || (fifo_q.size() == 0);
   endtask

   task automatic tick();
      @(posedge clk_r);
      #2;
   endtask

   // FIFO model: a pop strobe seen this cycle presents the next word after the edge.
   always @(negedge clk_r) re_s = red_enable;

   always @(posedge clk_r) begin
      #1;
      if (re_s) begin
         chk("pop_on_empty", fifo_q.size() == 0, 0);
         if (fifo_q.size() != 0) rdata = fifo_q.pop_front();
      end else begin
         rdata = $urandom;
      end
      re_s = 1'b0;
      upd_empty();
   end

   // Monitor and reference model
   always @(negedge clk_r) begin
      if (!reset_r) begin
         chk("rst_red_enable", red_enable, 0);
         chk("rst_m_valid", m_valid, 0);
         chk("rst_m_last", m_last, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_m_data", m_data, 0);
         chk("rst_stat_words", stat_words, 0);
         chk("rst_stat_starve", stat_starve, 0);
         mdl_active = 0; mdl_issued = 0; mdl_delivered = 0; mdl_inflight = 0; mdl_len = 0;
         done_exp = 0; prev_hold = 0; stat_w = 0; stat_s = 0;
         exp_q.delete();
      end else begin
         occ_m  = mdl_issued - int'(mdl_inflight) - mdl_delivered;
         exp_re = mdl_active && (mdl_issued < mdl_len) && !empty &&
                  ((mdl_issued - mdl_delivered) < 3);
         chk("red_enable", red_enable, exp_re);
         chk("m_valid", m_valid, mdl_active && (occ_m != 0));
         chk("busy", busy, mdl_active);
         chk("done", done, done_exp);
`ifdef RD_STATS_EN
         chk("stat_words", stat_words, stat_w);
         chk("stat_starve", stat_starve, stat_s);
`else
         chk("stat_words_tied", stat_words, 0);
         chk("stat_starve_tied", stat_starve, 0);
`endif
         if (prev_hold) begin
            chk("hold_data", m_data, prev_data);
            chk("hold_last", m_last, prev_last);
         end
         was_active = mdl_active;
         new_done   = 0;
         if (m_valid && m_ready && !abort) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", {m_last, m_data}, 0);
            end else begin
               e_word = exp_q.pop_front();
               chk("word", {m_last, m_data}, e_word);
            end
            mdl_delivered++;
            stat_w++;
            if (mdl_active && mdl_delivered == mdl_len) begin
               new_done   = 1;
               mdl_active = 0;
            end
         end
         if (was_active && (mdl_issued < mdl_len) && empty) stat_s++;
         if (red_enable) mdl_issued++;
         mdl_inflight = red_enable;
         if (was_active && abort) begin
            new_done   = 1;
            mdl_active = 0;
            exp_q.delete();
         end else if (!was_active && start && rel_cnt >= 2) begin
            if (burst_len == '0) begin
               new_done = 1;
            end else begin
               mdl_active    = 1;
               mdl_len       = int'(burst_len);
               mdl_issued    = 0;
               mdl_delivered = 0;
               mdl_inflight  = 0;
            end
         end
         prev_hold = m_valid && !m_ready && !abort;
         prev_data = m_data;
         prev_last = m_last;
         done_exp  = new_done;
      end
   end

   // Driver: fill the FIFO with len words plus two spares, queue the expected stream, run.
   task automatic run_burst(input int len, input int rmode, input int gap_pct,
                            input int gap_from, input int gap_len,
                            input int stall_from, input int stall_len,
                            input int abort_at, input bit check_tbl);
      logic [W-1:0] w;
      bit           got;
      fifo_q.delete();
      for (int i = 0; i < len + 2; i++) begin
         w = $urandom;
         fifo_q.push_back(w);
         if (i < len) exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, w});
      end
      force_empty = 1'b0;
      upd_empty();
      m_ready   = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      start     = 1'b1;
      burst_len = LEN_W'(len);
      tick();
      start     = 1'b0;
      burst_len = LEN_W'($urandom_range(0, 15));
      got = 0;
      for (int k = 1; k <= 2000; k++) begin
         if (check_tbl && k <= 7) begin
            chk("t1_red_enable", red_enable, t_re[k-1]);
            chk("t1_m_valid", m_valid, t_mv[k-1]);
            chk("t1_busy", busy, t_busy[k-1]);
            chk("t1_done", done, t_done[k-1]);
            chk("t1_m_last", m_last, t_last[k-1]);
         end
         if (done) begin
            got = 1;
            break;
         end
         abort       = (k == abort_at);
         force_empty = (k >= gap_from && k < gap_from + gap_len) ||
                       (int'($urandom_range(0, 99)) < gap_pct);
         upd_empty();
         if (k >= stall_from && k < stall_from + stall_len) m_ready = 1'b0;
         else m_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         tick();
      end
      abort       = 1'b0;
      force_empty = 1'b0;
      upd_empty();
      chk("done_seen", got, 1);
      if (abort_at < 0 && got) begin
         chk("pops_exact", fifo_q.size(), 2);
         chk("exp_drained", exp_q.size(), 0);
      end
   endtask

   task automatic reset_mid_burst();
      logic [W-1:0] w;
      fifo_q.delete();
      for (int i = 0; i < 12; i++) begin
         w = $urandom;
         fifo_q.push_back(w);
         if (i < 10) exp_q.push_back({(i == 9) ? 1'b1 : 1'b0, w});
      end
      upd_empty();
      m_ready   = 1'b1;
      start     = 1'b1;
      burst_len = LEN_W'(10);
      tick();
      start = 1'b0;
      repeat (3) tick();
      #1 reset_r = 1'b0;
      #1;
      chk("mid_rst_red_enable", red_enable, 0);
      chk("mid_rst_m_valid", m_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_m_data", m_data, 0);
      repeat (2) tick();
      reset_r = 1'b1;
      tick();
      start     = 1'b1;
      burst_len = LEN_W'(3);
      tick();
      start = 1'b0;
      repeat (2) tick();
      chk("early_start_busy", busy, 0);
      chk("early_start_red_enable", red_enable, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int len;
      int ab;
      reset_r = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
      burst_len = '0; rdata = '0;
      upd_empty();
      repeat (3) @(posedge clk_r);
      #2 reset_r = 1'b1;
      repeat (3) tick();
      chk("reset_m_valid", m_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_red_enable", red_enable, 0);

      run_burst(4, 0, 0, 0, 0, 0, 0, -1, 1);
      run_burst(8, 0, 0, 0, 0, 3, 8, -1, 0);
      s0 = int'(stat_starve);
      run_burst(6, 0, 0, 3, 5, 0, 0, -1, 0);
`ifdef RD_STATS_EN
      chk("starve_delta", int'(stat_starve) - s0, 5);
`else
      chk("starve_delta_tied", int'(stat_starve) - s0, 0);
`endif
      run_burst(8, 0, 0, 0, 0, 1, 50, 4, 0);
      chk("abort_m_valid", m_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 1);
      run_burst(5, 0, 0, 0, 0, 0, 0, -1, 0);
      run_burst(0, 0, 0, 0, 0, 0, 0, -1, 0);
      reset_mid_burst();
      run_burst(7, 1, 0, 0, 0, 0, 0, -1, 0);

      for (int n = 0; n < 30; n++) begin
         len = $urandom_range(0, 12);
         ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len + 5)) : -1;
         run_burst(len, $urandom_range(0, 1), $urandom_range(0, 30), 0, 0, 0, 0, ab, 0);
         repeat ($urandom_range(0, 2)) tick();
      end

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
